// File: rtl/lsu_mem.sv
// lsu_mem: MEM-stage load/store unit for the 5-stage RV32I pipeline.
// Converts the EX/MEM memory op into a req/gnt/rvalid bus transaction,
// stalls the front of the pipeline while it is in flight, and returns
// aligned, extended load data on DataR for MEM/WB.
module lsu_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        MemRW,
    input  logic        MemRd,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] DataW,
    output logic        stall,
    output logic        fault,
    output logic [31:0] DataR,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [29:0] r_waddr;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_datar;

    logic        w_memop;
    logic        w_bad;
    logic        w_idle;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_ext;

    assign w_memop = ex_valid & (MemRW | MemRd);
    assign w_idle  = (r_state == S_IDLE);

    // Classify the access: unsupported size, misalignment, or unsigned store.
    always_comb begin
        w_bad = 1'b0;
        case (Funct3)
            3'b000, 3'b100: w_bad = 1'b0;
            3'b001, 3'b101: w_bad = Addr[0];
            3'b010:         w_bad = (Addr[1:0] != 2'b00);
            default:        w_bad = 1'b1;
        endcase
        if (MemRW && Funct3[2])
            w_bad = 1'b1;
    end

    // Lane steering for stores; loads always read the full word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'h0;
        if (MemRW) begin
            case (Funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << Addr[1:0];
                    w_wdata = {4{DataW[7:0]}};
                end
                2'b01: begin
                    w_be    = Addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{DataW[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = DataW;
                end
            endcase
        end
    end

    // Pull the addressed bytes down to bit 0 and extend per the latched size.
    always_comb begin
        w_shift = dmem_rdata >> {r_off, 3'b000};
        case (r_f3)
            3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ext = {24'h0, w_shift[7:0]};
            3'b101:  w_ext = {16'h0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Transaction FSM; bus fields are latched on entry to REQ and held until gnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= 30'h0;
            r_off   <= 2'b00;
            r_f3    <= 3'b000;
            r_wdata <= 32'h0;
            r_be    <= 4'b0000;
            r_datar <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memop && !w_bad) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_we    <= MemRW;
                        r_waddr <= Addr[31:2];
                        r_off   <= Addr[1:0];
                        r_f3    <= Funct3;
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= r_we ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        r_datar <= w_ext;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall      = (w_idle & w_memop & ~w_bad) | (r_state == S_REQ) | (r_state == S_WAIT);
    assign fault      = w_idle & w_memop & w_bad;
    assign DataR      = r_datar;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = {r_waddr, 2'b00};
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: table-driven bench for lsu_mem with a small bus responder
// and a load-data scoreboard, plus a hand sequence for reset mid-transaction.
module tb_lsu_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, MemRW, MemRd;
    logic [2:0]  Funct3;
    logic [31:0] Addr, DataW;
    logic        stall, fault;
    logic [31:0] DataR;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    lsu_mem dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .MemRW(MemRW), .MemRd(MemRd),
        .Funct3(Funct3), .Addr(Addr), .DataW(DataW), .stall(stall), .fault(fault),
        .DataR(DataR), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        ev, rw, rd;
        bit [2:0]  f3;
        bit [31:0] addr, dataw, rdata;
        int        gdly;
        bit        ef;
        bit [31:0] eaddr;
        bit [3:0]  ebe;
        bit [31:0] ewdata, edatar;
        int        estall;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] sb[$];
    logic [31:0] model_datar;
    int          total = 0;
    int          bad = 0;

    function automatic vec_t mk(bit ev, bit rw, bit rd, bit [2:0] f3, bit [31:0] addr,
                                bit [31:0] dataw, bit [31:0] rdata, int gdly, bit ef,
                                bit [31:0] eaddr, bit [3:0] ebe, bit [31:0] ewdata,
                                bit [31:0] edatar, int estall);
        vec_t v;
        v.ev = ev; v.rw = rw; v.rd = rd; v.f3 = f3; v.addr = addr; v.dataw = dataw;
        v.rdata = rdata; v.gdly = gdly; v.ef = ef; v.eaddr = eaddr; v.ebe = ebe;
        v.ewdata = ewdata; v.edatar = edatar; v.estall = estall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
        end
    endtask

    // Drive one EX/MEM op, act as the bus, and check every cycle until DONE.
    task automatic run_vec(input int idx, input vec_t v);
        int nst;
        logic [31:0] exp;
        @(negedge clk);
        ex_valid = v.ev; MemRW = v.rw; MemRd = v.rd; Funct3 = v.f3;
        Addr = v.addr; DataW = v.dataw; dmem_rdata = v.rdata;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        chk($sformatf("v%0d fault", idx), {31'h0, fault}, {31'h0, v.ef});
        if (!(v.ev && (v.rw || v.rd)) || v.ef) begin
            chk($sformatf("v%0d stall_none", idx), {31'h0, stall}, 32'h0);
            chk($sformatf("v%0d req_none", idx), {31'h0, dmem_req}, 32'h0);
            chk($sformatf("v%0d datar_hold", idx), DataR, model_datar);
            return;
        end
        if (!v.rw) sb.push_back(v.edatar);
        nst = stall ? 1 : 0;
        @(negedge clk);
        #1;
        for (int k = 0; k <= v.gdly; k++) begin
            chk($sformatf("v%0d req", idx), {31'h0, dmem_req}, 32'h1);
            chk($sformatf("v%0d addr", idx), dmem_addr, v.eaddr);
            chk($sformatf("v%0d be", idx), {28'h0, dmem_be}, {28'h0, v.ebe});
            chk($sformatf("v%0d wdata", idx), dmem_wdata, v.ewdata);
            chk($sformatf("v%0d we", idx), {31'h0, dmem_we}, {31'h0, v.rw});
            if (stall) nst++;
            dmem_gnt = (k == v.gdly);
            @(negedge clk);
            dmem_gnt = 1'b0;
            #1;
        end
        if (!v.rw) begin
            chk($sformatf("v%0d req_wait", idx), {31'h0, dmem_req}, 32'h0);
            if (stall) nst++;
            dmem_rvalid = 1'b1;
            @(negedge clk);
            dmem_rvalid = 1'b0;
            #1;
        end
        chk($sformatf("v%0d stall_cycles", idx), nst, v.estall);
        chk($sformatf("v%0d stall_done", idx), {31'h0, stall}, 32'h0);
        chk($sformatf("v%0d req_done", idx), {31'h0, dmem_req}, 32'h0);
        if (!v.rw) begin
            if (sb.size() == 0) begin
                chk($sformatf("v%0d sb_empty", idx), 32'h1, 32'h0);
            end else begin
                exp = sb.pop_front();
                model_datar = exp;
                chk($sformatf("v%0d datar", idx), DataR, exp);
            end
        end else begin
            chk($sformatf("v%0d datar_hold", idx), DataR, model_datar);
        end
    endtask

    initial begin
        //           ev rw rd f3      addr          dataw         rdata         g  ef eaddr         be       ewdata        edatar        st
        vt.push_back(mk(1, 0, 0, 3'b010, 32'h0000_0010, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
        vt.push_back(mk(1, 1, 0, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0,        0, 0, 32'h0000_0300, 4'b1111, 32'h1234_5678, 32'h0,        2));
        vt.push_back(mk(1, 0, 1, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 3));
        vt.push_back(mk(1, 0, 1, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80, 3));
        vt.push_back(mk(1, 0, 1, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0080, 3));
        vt.push_back(mk(1, 0, 1, 3'b101, 32'h0000_0102, 32'h0,        32'hBEEF_1234, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_BEEF, 3));
        vt.push_back(mk(1, 0, 1, 3'b001, 32'h0000_0102, 32'h0,        32'hBEEF_1234, 1, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_BEEF, 4));
        vt.push_back(mk(1, 1, 0, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0,        3, 0, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 32'h0,        5));
        vt.push_back(mk(1, 1, 0, 3'b001, 32'h0000_0206, 32'h1234_CAFE, 32'h0,        0, 0, 32'h0000_0204, 4'b1100, 32'hCAFE_CAFE, 32'h0,        2));
        vt.push_back(mk(1, 0, 1, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
        vt.push_back(mk(1, 1, 0, 3'b001, 32'h0000_0105, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
        vt.push_back(mk(1, 0, 1, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
        vt.push_back(mk(1, 1, 0, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
        vt.push_back(mk(1, 0, 1, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 2, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_007F, 5));
        vt.push_back(mk(1, 1, 1, 3'b010, 32'h0000_0400, 32'hA5A5_A5A5, 32'h0,        0, 0, 32'h0000_0400, 4'b1111, 32'hA5A5_A5A5, 32'h0,        2));
        vt.push_back(mk(0, 0, 1, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
        vt.push_back(mk(1, 0, 1, 3'b101, 32'h0000_0100, 32'h0,        32'hFFFF_8001, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_8001, 3));

        reset = 1'b1; ex_valid = 1'b0; MemRW = 1'b0; MemRd = 1'b0; Funct3 = 3'b000;
        Addr = 32'h0; DataW = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        model_datar = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst DataR", DataR, 32'h0);
        chk("rst req", {31'h0, dmem_req}, 32'h0);
        chk("rst stall", {31'h0, stall}, 32'h0);
        chk("rst fault", {31'h0, fault}, 32'h0);
        chk("rst addr", dmem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) run_vec(i, vt[i]);

        // Reset while waiting for read data; the late rvalid must be ignored.
        @(negedge clk);
        ex_valid = 1'b1; MemRW = 1'b0; MemRd = 1'b1; Funct3 = 3'b010; Addr = 32'h500;
        dmem_rdata = 32'hCAFE_F00D;
        #1;
        chk("rw stall_idle", {31'h0, stall}, 32'h1);
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("rw stall_wait", {31'h0, stall}, 32'h1);
        ex_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_datar = 32'h0;
        chk("rw DataR", DataR, 32'h0);
        chk("rw stall", {31'h0, stall}, 32'h0);
        chk("rw req", {31'h0, dmem_req}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        chk("rw late_rvalid DataR", DataR, 32'h0);
        chk("rw late_rvalid stall", {31'h0, stall}, 32'h0);

        run_vec(100, mk(1, 0, 1, 3'b010, 32'h0000_0600, 32'h0, 32'h1122_3344, 0, 0,
                        32'h0000_0600, 4'b1111, 32'h0, 32'h1122_3344, 3));

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
